icache_axi_rd_bridge: RTL and testbench

//  Memory-side responder for the icache refill/uncache read request interface (addr_valid/addr/data_len -> resp_ready,

---
 rtl/icache_axi_rd_bridge_pkg.sv | 22 ++
 rtl/icache_axi_rd_bridge.sv | 172 +++++++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_rd_bridge_pkg.sv
// ============================================================================
//  Module   : icache_axi_rd_bridge_pkg
//  Purpose  : AXI constants and the latched icache read-request type.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package icache_axi_rd_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } icache_rd_req_t;

endpackage

`default_nettype wire

// File: rtl/icache_axi_rd_bridge.sv
// ============================================================================
//  Module   : icache_axi_rd_bridge
//  Purpose  : Turns one icache read request into a single AXI4 INCR read burst
//             and streams the returned words back, one per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module icache_axi_rd_bridge
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int AXI_ID   = 0,
  parameter int MAX_LEN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                addr_valid_i,
  input  logic [31:0]         addr_i,
  input  logic [7:0]          data_len_i,
  output logic                resp_ready_o,
  output logic                data_valid_o,
  output logic [31:0]         data_o,
  output logic                bus_err_o,
  input  logic                cancel_i,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_RDATA = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [7:0]          MAX_LEN_W = 8'(MAX_LEN);
  localparam logic [ID_WIDTH-1:0] AXI_ID_W  = ID_WIDTH'(AXI_ID);

  state_e         state_q, state_d;
  icache_rd_req_t req_q, req_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic           err_q, err_d;
  logic           cancel_q, cancel_d;
  logic           resp_zero_q, resp_zero_d;
  logic           data_valid_q, data_valid_d;
  logic [31:0]    data_q, data_d;
  logic           bus_err_q, bus_err_d;

  logic [7:0]     len_clamp;
  logic           cancel_any;
  logic           beat_ok;
  logic           last_exp;
  logic           err_beat;

  // arlen is words-1; the guard keeps it at 0 out of reset.
  assign arlen   = req_q.len - 8'(req_q.len != 8'd0);
  assign araddr  = req_q.addr;
  assign arid    = AXI_ID_W;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (state_q == S_AR);
  assign rready  = (state_q == S_RDATA) || (state_q == S_DRAIN);

  assign cancel_any   = cancel_q | cancel_i;
  assign resp_ready_o = resp_zero_q | ((state_q == S_AR) & arready & ~cancel_any);
  assign data_valid_o = data_valid_q;
  assign data_o       = data_q;
  assign bus_err_o    = bus_err_q;

  always_comb begin
    len_clamp    = (data_len_i > MAX_LEN_W) ? MAX_LEN_W : data_len_i;
    beat_ok      = (state_q == S_RDATA) && rvalid && (rid == AXI_ID_W);
    last_exp     = (beat_cnt_q == arlen);
    // Burst length mismatch shows up as rlast disagreeing with the expected last beat.
    err_beat     = err_q | (rresp != AXI_RESP_OKAY) | (last_exp != rlast);

    state_d      = state_q;
    req_d        = req_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    cancel_d     = cancel_q;
    resp_zero_d  = 1'b0;
    data_valid_d = 1'b0;
    data_d       = data_q;
    bus_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (addr_valid_i) begin
          if (len_clamp == 8'd0) begin
            resp_zero_d = 1'b1;
          end else begin
            req_d.addr = addr_i;
            req_d.len  = len_clamp;
            beat_cnt_d = 8'd0;
            err_d      = 1'b0;
            cancel_d   = 1'b0;
            state_d    = S_AR;
          end
        end
      end
      S_AR: begin
        cancel_d = cancel_any;
        if (arready) begin
          state_d = cancel_any ? S_DRAIN : S_RDATA;
        end
      end
      S_RDATA: begin
        if (beat_ok) begin
          data_d       = rdata;
          data_valid_d = 1'b1;
          beat_cnt_d   = beat_cnt_q + 8'd1;
          err_d        = err_beat;
          if (last_exp || rlast) begin
            bus_err_d = err_beat;
            state_d   = (last_exp && !rlast) ? S_DRAIN : S_IDLE;
          end else if (cancel_i) begin
            state_d = S_DRAIN;
          end
        end else if (cancel_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rvalid && rlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      beat_cnt_q   <= 8'd0;
      err_q        <= 1'b0;
      cancel_q     <= 1'b0;
      resp_zero_q  <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= 32'd0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      cancel_q     <= cancel_d;
      resp_zero_q  <= resp_zero_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      bus_err_q    <= bus_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_axi_rd_bridge.sv
// ============================================================================
//  Module   : tb_icache_axi_rd_bridge
//  Purpose  : Self-checking bench for icache_axi_rd_bridge.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_icache_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_valid_i;
  logic [31:0] addr_i;
  logic [7:0]  data_len_i;
  logic        resp_ready_o;
  logic        data_valid_o;
  logic [31:0] data_o;
  logic        bus_err_o;
  logic        cancel_i;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   resp_cnt = 0;
  int   dv_cnt   = 0;
  int   ar_cyc   = 0;

  always #5 clk = ~clk;

  icache_axi_rd_bridge #(.ID_WIDTH(4), .AXI_ID(0), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .addr_valid_i(addr_valid_i), .addr_i(addr_i), .data_len_i(data_len_i),
    .resp_ready_o(resp_ready_o), .data_valid_o(data_valid_o), .data_o(data_o),
    .bus_err_o(bus_err_o), .cancel_i(cancel_i),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // Scoreboard: every forwarded word is matched against the queue head.
  always @(negedge clk) begin
    if (resp_ready_o) resp_cnt++;
    if (arvalid)      ar_cyc++;
    if (bus_err_o && !data_valid_o) begin
      n_tests++; n_fail++;
      $display("FAIL bus_err_alone: bus_err_o=1 with data_valid_o=0, required pulse only with a word");
    end
    if (data_valid_o) begin
      dv_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data_o=%h, required no data_valid_o", data_o);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e.data || bus_err_o !== e.err) begin
          n_fail++;
          $display("FAIL word: got data=%h err=%b, required data=%h err=%b", data_o, bus_err_o, e.data, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                           input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    rvalid = 1'b1; rid = id; rdata = d; rresp = resp; rlast = last;
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic issue_req(input logic [31:0] a, input logic [7:0] l, input int ar_delay,
                           input logic [7:0] exp_len, input bit do_cancel);
    addr_valid_i = 1'b1; addr_i = a; data_len_i = l;
    @(posedge clk); #1;
    n_tests++;
    if (arvalid !== 1'b1 || araddr !== a || arlen !== exp_len || arsize !== 3'b010 ||
        arburst !== 2'b01 || arid !== 4'h0) begin
      n_fail++;
      $display("FAIL ar_issue: got arvalid=%b araddr=%h arlen=%0d size=%b burst=%b, required 1 %h %0d 010 01",
               arvalid, araddr, arlen, arsize, arburst, a, exp_len);
    end
    if (do_cancel) cancel_i = 1'b1;
    for (int i = 0; i < ar_delay; i++) begin @(posedge clk); #1; cancel_i = 1'b0; end
    n_tests++;
    if (arvalid !== 1'b1 || araddr !== a || arlen !== exp_len) begin
      n_fail++;
      $display("FAIL ar_hold: got arvalid=%b araddr=%h arlen=%0d, required 1 %h %0d", arvalid, araddr, arlen, a, exp_len);
    end
    arready = 1'b1;
    #1;
    n_tests++;
    if (resp_ready_o !== (do_cancel ? 1'b0 : 1'b1)) begin
      n_fail++;
      $display("FAIL resp_at_hs: got resp_ready_o=%b, required %b", resp_ready_o, !do_cancel);
    end
    @(posedge clk); #1;
    arready = 1'b0; addr_valid_i = 1'b0; cancel_i = 1'b0;
    n_tests++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_hs: got arvalid=%b rready=%b, required 0 1", arvalid, rready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; addr_valid_i = 0; addr_i = 0; data_len_i = 0; cancel_i = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (arvalid !== 0 || rready !== 0 || resp_ready_o !== 0 || data_valid_o !== 0 ||
        bus_err_o !== 0 || data_o !== 0 || araddr !== 0 || arlen !== 0) begin
      n_fail++;
      $display("FAIL reset: got arv=%b rr=%b resp=%b dv=%b err=%b data=%h addr=%h len=%0d, required all 0",
               arvalid, rready, resp_ready_o, data_valid_o, bus_err_o, data_o, araddr, arlen);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_burst8();
    int r0 = resp_cnt;
    int d0 = dv_cnt;
    issue_req(32'h1C000020, 8'd8, 2, 8'd7, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back('{data: 32'hA0 + i, err: 1'b0});
    for (int i = 0; i < 8; i++) send_beat(4'h0, 32'hA0 + i, 2'b00, i == 7, 0);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (resp_cnt - r0 !== 1 || dv_cnt - d0 !== 8 || exp_q.size() !== 0 || rready !== 0) begin
      n_fail++;
      $display("FAIL burst8_totals: got resp=%0d words=%0d left=%0d rready=%b, required 1 8 0 0",
               resp_cnt - r0, dv_cnt - d0, exp_q.size(), rready);
    end
  endtask

  task automatic test_len1_gaps();
    int d0 = dv_cnt;
    issue_req(32'h1C000004, 8'd1, 0, 8'd0, 1'b0);
    send_beat(4'h3, 32'h0000DEAD, 2'b00, 1'b1, 3);
    exp_q.push_back('{data: 32'h12345678, err: 1'b0});
    send_beat(4'h0, 32'h12345678, 2'b00, 1'b1, 3);
    issue_req(32'h1C000008, 8'd1, 0, 8'd0, 1'b0);
    exp_q.push_back('{data: 32'h9ABCDEF0, err: 1'b0});
    send_beat(4'h0, 32'h9ABCDEF0, 2'b00, 1'b1, 3);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (dv_cnt - d0 !== 2 || exp_q.size() !== 0 || rready !== 0) begin
      n_fail++;
      $display("FAIL len1_totals: got words=%0d left=%0d rready=%b, required 2 0 0", dv_cnt - d0, exp_q.size(), rready);
    end
  endtask

  task automatic test_len0();
    int a0 = ar_cyc;
    int r0 = resp_cnt;
    addr_valid_i = 1'b1; addr_i = 32'h1C000100; data_len_i = 8'd0;
    @(posedge clk); #1;
    addr_valid_i = 1'b0;
    n_tests++;
    if (resp_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL len0_resp: got resp_ready_o=%b, required 1", resp_ready_o);
    end
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (ar_cyc - a0 !== 0 || resp_cnt - r0 !== 1) begin
      n_fail++;
      $display("FAIL len0_traffic: got ar_cycles=%0d resp_pulses=%0d, required 0 1", ar_cyc - a0, resp_cnt - r0);
    end
  endtask

  task automatic test_clamp();
    int d0 = dv_cnt;
    issue_req(32'h1C000200, 8'd20, 1, 8'd15, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back('{data: 32'hC00 + i, err: 1'b0});
    for (int i = 0; i < 16; i++) send_beat(4'h0, 32'hC00 + i, 2'b00, i == 15, 0);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (dv_cnt - d0 !== 16 || exp_q.size() !== 0 || rready !== 0) begin
      n_fail++;
      $display("FAIL clamp_totals: got words=%0d left=%0d rready=%b, required 16 0 0", dv_cnt - d0, exp_q.size(), rready);
    end
  endtask

  task automatic test_rresp_err();
    int d0 = dv_cnt;
    issue_req(32'h1C000300, 8'd8, 0, 8'd7, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back('{data: 32'hB0 + i, err: (i == 7)});
    for (int i = 0; i < 8; i++) send_beat(4'h0, 32'hB0 + i, (i == 2) ? 2'b10 : 2'b00, i == 7, 0);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (dv_cnt - d0 !== 8 || exp_q.size() !== 0 || rready !== 0) begin
      n_fail++;
      $display("FAIL rresp_totals: got words=%0d left=%0d rready=%b, required 8 0 0", dv_cnt - d0, exp_q.size(), rready);
    end
  endtask

  task automatic test_rlast_mismatch();
    int d0 = dv_cnt;
    issue_req(32'h1C000400, 8'd8, 0, 8'd7, 1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back('{data: 32'hE0 + i, err: (i == 4)});
    for (int i = 0; i < 5; i++) send_beat(4'h0, 32'hE0 + i, 2'b00, i == 4, 0);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (dv_cnt - d0 !== 5 || exp_q.size() !== 0 || rready !== 0) begin
      n_fail++;
      $display("FAIL early_rlast: got words=%0d left=%0d rready=%b, required 5 0 0", dv_cnt - d0, exp_q.size(), rready);
    end
    d0 = dv_cnt;
    issue_req(32'h1C000500, 8'd2, 0, 8'd1, 1'b0);
    exp_q.push_back('{data: 32'hF0, err: 1'b0});
    exp_q.push_back('{data: 32'hF1, err: 1'b1});
    for (int i = 0; i < 4; i++) send_beat(4'h0, 32'hF0 + i, 2'b00, i == 3, 0);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (dv_cnt - d0 !== 2 || exp_q.size() !== 0 || rready !== 0) begin
      n_fail++;
      $display("FAIL late_rlast: got words=%0d left=%0d rready=%b, required 2 0 0", dv_cnt - d0, exp_q.size(), rready);
    end
  endtask

  task automatic test_cancel();
    int d0 = dv_cnt;
    int r0 = resp_cnt;
    issue_req(32'h1C000600, 8'd4, 3, 8'd3, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(4'h0, 32'h600 + i, 2'b00, i == 3, 0);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (dv_cnt - d0 !== 0 || resp_cnt - r0 !== 0 || rready !== 0) begin
      n_fail++;
      $display("FAIL cancel_ar: got words=%0d resp=%0d rready=%b, required 0 0 0", dv_cnt - d0, resp_cnt - r0, rready);
    end
    d0 = dv_cnt;
    issue_req(32'h1C000700, 8'd4, 0, 8'd3, 1'b0);
    exp_q.push_back('{data: 32'h700, err: 1'b0});
    exp_q.push_back('{data: 32'h701, err: 1'b0});
    send_beat(4'h0, 32'h700, 2'b00, 1'b0, 0);
    cancel_i = 1'b1;
    send_beat(4'h0, 32'h701, 2'b00, 1'b0, 0);
    cancel_i = 1'b0;
    send_beat(4'h0, 32'h702, 2'b00, 1'b0, 1);
    send_beat(4'h0, 32'h703, 2'b00, 1'b1, 0);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (dv_cnt - d0 !== 2 || exp_q.size() !== 0 || rready !== 0) begin
      n_fail++;
      $display("FAIL cancel_rdata: got words=%0d left=%0d rready=%b, required 2 0 0", dv_cnt - d0, exp_q.size(), rready);
    end
  endtask

  task automatic test_reset_mid();
    issue_req(32'h1C000800, 8'd8, 0, 8'd7, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back('{data: 32'h800 + i, err: 1'b0});
    for (int i = 0; i < 3; i++) send_beat(4'h0, 32'h800 + i, 2'b00, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (arvalid !== 0 || rready !== 0 || resp_ready_o !== 0 || data_valid_o !== 0 ||
        bus_err_o !== 0 || data_o !== 0 || araddr !== 0 || arlen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: got arv=%b rr=%b resp=%b dv=%b err=%b data=%h addr=%h len=%0d, required all 0",
               arvalid, rready, resp_ready_o, data_valid_o, bus_err_o, data_o, araddr, arlen);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_words: got %0d words missing, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_burst8();
    test_len1_gaps();
    test_len0();
    test_clamp();
    test_rresp_err();
    test_rlast_mismatch();
    test_cancel();
    test_reset_mid();
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d outstanding words, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
